index_stream_to_word: RTL and testbench

- Rebuilds a DATA_WD-bit word from a stream of bit indices, one index per handshake; the stream is the inverse of leading-one detection.
- Each accepted index sets that bit in an accumulator. An index flagged "last" closes the word and presents it downstream on a valid/ready interface.
- Sits after the set-bit iterator path: the iterator emits indices of set bits, and this block reassembles the original vector for checking or forwarding.

---
 rtl/index_stream_pkg.sv | 8 +
 rtl/index_to_onehot.sv | 38 +++
 rtl/index_stream_to_word.sv | 116 +++++++++++
 tb/tb_index_stream_to_word.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/index_stream_pkg.sv
// Shared types and default width for the index-stream word rebuilder.
package index_stream_pkg;

  localparam int LP_DATA_WD = 8;

  typedef enum logic {ACCUM, HOLD} idx_acc_state_t;

endpackage : index_stream_pkg

// File: rtl/index_to_onehot.sv
// Decodes a bit index into a one-hot vector; the inverse of leading-one detection
// for single-bit vectors. Out-of-range indices give an all-zero vector and o_oor.
module index_to_onehot
  import index_stream_pkg::*;
#(
  parameter int DATA_WD = LP_DATA_WD,
  parameter int IND_WD  = $clog2(DATA_WD)
) (
  input  logic [IND_WD-1:0]  i_idx,
  input  logic               i_en,
  output logic [DATA_WD-1:0] o_onehot,
  output logic               o_oor
);

  localparam logic [IND_WD:0] LP_LIMIT = (IND_WD + 1)'(DATA_WD);

  logic w_oor;

  assign w_oor = ({1'b0, i_idx} >= LP_LIMIT);

  // one-hot decode gated by enable and range
  always_comb begin
    o_onehot = '0;
    o_oor    = 1'b0;
    if (i_en) begin
      o_oor = w_oor;
      if (!w_oor) begin
        o_onehot = DATA_WD'(1) << i_idx;
      end else begin
        o_onehot = '0;
      end
    end else begin
      o_onehot = '0;
      o_oor    = 1'b0;
    end
  end

endmodule : index_to_onehot

// File: rtl/index_stream_to_word.sv
// Rebuilds a DATA_WD-bit word from a stream of set-bit indices and hands the
// finished word downstream on a valid/ready interface with sticky error flags.
module index_stream_to_word
  import index_stream_pkg::*;
#(
  parameter int DATA_WD = LP_DATA_WD,
  parameter int IND_WD  = $clog2(DATA_WD),
  parameter int CNT_WD  = $clog2(DATA_WD + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_idx_valid,
  output logic               o_idx_ready,
  input  logic [IND_WD-1:0]  i_idx,
  input  logic               i_idx_last,
  output logic               o_word_valid,
  input  logic               i_word_ready,
  output logic [DATA_WD-1:0] o_word,
  output logic [CNT_WD-1:0]  o_count,
  output logic               o_dup_err,
  output logic               o_range_err
);

  idx_acc_state_t     r_state;
  logic               r_idx_ready;
  logic               r_word_valid;
  logic [DATA_WD-1:0] r_acc;
  logic [CNT_WD-1:0]  r_count;
  logic               r_dup;
  logic               r_range;

  logic               w_accept;
  logic [DATA_WD-1:0] w_onehot;
  logic               w_oor;
  logic               w_dup;

  assign w_accept = i_idx_valid & r_idx_ready;
  assign w_dup    = |(w_onehot & r_acc);

  index_to_onehot #(
    .DATA_WD (DATA_WD),
    .IND_WD  (IND_WD)
  ) u_onehot (
    .i_idx    (i_idx),
    .i_en     (w_accept),
    .o_onehot (w_onehot),
    .o_oor    (w_oor)
  );

  // accumulate/hold FSM; ready only rises after reset release, never from i_word_ready combinationally
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ACCUM;
      r_idx_ready  <= 1'b0;
      r_word_valid <= 1'b0;
      r_acc        <= '0;
      r_count      <= '0;
      r_dup        <= 1'b0;
      r_range      <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            if (w_oor) begin
              r_range <= 1'b1;
            end else if (w_dup) begin
              r_dup <= 1'b1;
            end else begin
              r_acc   <= r_acc | w_onehot;
              r_count <= r_count + CNT_WD'(1);
            end
            if (i_idx_last) begin
              r_state      <= HOLD;
              r_idx_ready  <= 1'b0;
              r_word_valid <= 1'b1;
            end else begin
              r_idx_ready  <= 1'b1;
            end
          end else begin
            r_idx_ready <= 1'b1;
          end
        end
        HOLD: begin
          if (i_word_ready) begin
            r_state      <= ACCUM;
            r_idx_ready  <= 1'b1;
            r_word_valid <= 1'b0;
            r_acc        <= '0;
            r_count      <= '0;
            r_dup        <= 1'b0;
            r_range      <= 1'b0;
          end else begin
            r_idx_ready  <= 1'b0;
          end
        end
        default: begin
          r_state      <= ACCUM;
          r_idx_ready  <= 1'b0;
          r_word_valid <= 1'b0;
          r_acc        <= '0;
          r_count      <= '0;
          r_dup        <= 1'b0;
          r_range      <= 1'b0;
        end
      endcase
    end
  end

  assign o_idx_ready  = r_idx_ready;
  assign o_word_valid = r_word_valid;
  assign o_word       = r_acc;
  assign o_count      = r_count;
  assign o_dup_err    = r_dup;
  assign o_range_err  = r_range;

endmodule : index_stream_to_word

// File: tb/tb_index_stream_to_word.sv
// Self-checking bench: directed table, multi-cycle corner sequences and a
// randomized run scored against a set-union reference model.
module tb_index_stream_to_word;

  logic       clk;
  logic       rst_n;
  logic       i_idx_valid;
  logic       o_idx_ready;
  logic [2:0] i_idx;
  logic       i_idx_last;
  logic       o_word_valid;
  logic       i_word_ready;
  logic [7:0] o_word;
  logic [3:0] o_count;
  logic       o_dup_err;
  logic       o_range_err;

  logic       d6_idx_valid;
  logic       d6_idx_ready;
  logic [2:0] d6_idx;
  logic       d6_idx_last;
  logic       d6_word_valid;
  logic       d6_word_ready;
  logic [5:0] d6_word;
  logic [2:0] d6_count;
  logic       d6_dup_err;
  logic       d6_range_err;

  int checks = 0;
  int errors = 0;

  index_stream_to_word #(.DATA_WD(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_idx_valid(i_idx_valid), .o_idx_ready(o_idx_ready),
    .i_idx(i_idx), .i_idx_last(i_idx_last),
    .o_word_valid(o_word_valid), .i_word_ready(i_word_ready),
    .o_word(o_word), .o_count(o_count),
    .o_dup_err(o_dup_err), .o_range_err(o_range_err)
  );

  index_stream_to_word #(.DATA_WD(6)) dut6 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_idx_valid(d6_idx_valid), .o_idx_ready(d6_idx_ready),
    .i_idx(d6_idx), .i_idx_last(d6_idx_last),
    .o_word_valid(d6_word_valid), .i_word_ready(d6_word_ready),
    .o_word(d6_word), .o_count(d6_count),
    .o_dup_err(d6_dup_err), .o_range_err(d6_range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [2:0] idx [8];
    logic [7:0] exp_word;
    logic [3:0] exp_count;
    logic       exp_dup;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Presents one beat and returns just after the edge that accepted it.
  task automatic send_beat(input logic [2:0] idx, input logic last);
    int t;
    t = 0;
    @(negedge clk);
    i_idx_valid = 1'b1;
    i_idx       = idx;
    i_idx_last  = last;
    while (!o_idx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!o_idx_ready) chk("idx_ready_timeout", 32'(o_idx_ready), 32'd1);
    @(posedge clk);
    #1;
    i_idx_valid = 1'b0;
    i_idx_last  = 1'b0;
  endtask

  // Called right after the last beat: checks one-cycle latency, stalls, then hands off.
  task automatic finish_word(input logic [7:0] w, input logic [3:0] c,
                             input logic d, input int stall);
    @(negedge clk);
    chk("word_valid_latency", 32'(o_word_valid), 32'd1);
    chk("idx_ready_in_hold", 32'(o_idx_ready), 32'd0);
    chk("word", 32'(o_word), 32'(w));
    chk("count", 32'(o_count), 32'(c));
    chk("dup_err", 32'(o_dup_err), 32'(d));
    chk("range_err", 32'(o_range_err), 32'd0);
    for (int s = 0; s < stall; s++) begin
      i_word_ready = 1'b0;
      @(negedge clk);
      chk("word_stable_stall", 32'(o_word), 32'(w));
      chk("valid_stable_stall", 32'(o_word_valid), 32'd1);
    end
    i_word_ready = 1'b1;
    @(posedge clk);
    #1;
    i_word_ready = 1'b0;
    @(negedge clk);
    chk("idx_ready_after_handoff", 32'(o_idx_ready), 32'd1);
    chk("valid_cleared", 32'(o_word_valid), 32'd0);
    chk("word_cleared", 32'(o_word), 32'd0);
    chk("dup_cleared", 32'(o_dup_err), 32'd0);
  endtask

  initial begin
    vec_t       vecs [4];
    logic [2:0] q [$];
    logic [7:0] mw;
    int         n;

    rst_n = 1'b0;
    i_idx_valid = 1'b0; i_idx = 3'd0; i_idx_last = 1'b0; i_word_ready = 1'b0;
    d6_idx_valid = 1'b0; d6_idx = 3'd0; d6_idx_last = 1'b0; d6_word_ready = 1'b0;

    vecs[0].n = 3; vecs[0].idx[0] = 3'd7; vecs[0].idx[1] = 3'd3; vecs[0].idx[2] = 3'd0;
    vecs[0].exp_word = 8'h89; vecs[0].exp_count = 4'd3; vecs[0].exp_dup = 1'b0;
    vecs[1].n = 2; vecs[1].idx[0] = 3'd2; vecs[1].idx[1] = 3'd2;
    vecs[1].exp_word = 8'h04; vecs[1].exp_count = 4'd1; vecs[1].exp_dup = 1'b1;
    vecs[2].n = 1; vecs[2].idx[0] = 3'd5;
    vecs[2].exp_word = 8'h20; vecs[2].exp_count = 4'd1; vecs[2].exp_dup = 1'b0;
    vecs[3].n = 4; vecs[3].idx[0] = 3'd6; vecs[3].idx[1] = 3'd1; vecs[3].idx[2] = 3'd6;
    vecs[3].idx[3] = 3'd1;
    vecs[3].exp_word = 8'h42; vecs[3].exp_count = 4'd2; vecs[3].exp_dup = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset_word_valid", 32'(o_word_valid), 32'd0);
    chk("reset_idx_ready", 32'(o_idx_ready), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_idx_ready", 32'(o_idx_ready), 32'd1);
    chk("idle_word_valid", 32'(o_word_valid), 32'd0);
    chk("idle_word", 32'(o_word), 32'd0);
    chk("idle_count", 32'(o_count), 32'd0);
    chk("idle_dup", 32'(o_dup_err), 32'd0);
    chk("idle_range", 32'(o_range_err), 32'd0);

    // Directed table; word_ready held high during beats has no effect in ACCUM.
    for (int v = 0; v < 4; v++) begin
      i_word_ready = 1'b1;
      for (int b = 0; b < vecs[v].n; b++)
        send_beat(vecs[v].idx[b], (b == vecs[v].n - 1) ? 1'b1 : 1'b0);
      finish_word(vecs[v].exp_word, vecs[v].exp_count, vecs[v].exp_dup, 0);
    end

    // Backpressure with a pending beat that must wait for the handoff.
    for (int b = 0; b < 8; b++) send_beat(3'(b), (b == 7) ? 1'b1 : 1'b0);
    i_idx_valid = 1'b1; i_idx = 3'd1; i_idx_last = 1'b1;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      chk("bp_word", 32'(o_word), 32'hFF);
      chk("bp_count", 32'(o_count), 32'd8);
      chk("bp_idx_ready", 32'(o_idx_ready), 32'd0);
      chk("bp_valid", 32'(o_word_valid), 32'd1);
    end
    i_word_ready = 1'b1;
    @(posedge clk);
    #1;
    i_word_ready = 1'b0;
    @(negedge clk);
    chk("bp_bubble_word", 32'(o_word), 32'd0);
    chk("bp_bubble_ready", 32'(o_idx_ready), 32'd1);
    @(posedge clk);
    #1;
    i_idx_valid = 1'b0; i_idx_last = 1'b0;
    finish_word(8'h02, 4'd1, 1'b0, 1);

    // DATA_WD=6 instance: index 6 is out of range.
    @(negedge clk);
    d6_idx_valid = 1'b1; d6_idx = 3'd6; d6_idx_last = 1'b0;
    @(negedge clk);
    d6_idx = 3'd1; d6_idx_last = 1'b1;
    @(negedge clk);
    d6_idx_valid = 1'b0; d6_idx_last = 1'b0;
    chk("d6_valid", 32'(d6_word_valid), 32'd1);
    chk("d6_word", 32'(d6_word), 32'h02);
    chk("d6_count", 32'(d6_count), 32'd1);
    chk("d6_range_err", 32'(d6_range_err), 32'd1);
    chk("d6_dup_err", 32'(d6_dup_err), 32'd0);
    d6_word_ready = 1'b1;
    @(negedge clk);
    d6_word_ready = 1'b0;
    chk("d6_range_cleared", 32'(d6_range_err), 32'd0);
    chk("d6_ready_back", 32'(d6_idx_ready), 32'd1);

    // Reset mid-word discards the partial word.
    send_beat(3'd4, 1'b0);
    send_beat(3'd5, 1'b0);
    @(negedge clk);
    chk("pre_reset_word", 32'(o_word), 32'h30);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_word", 32'(o_word), 32'd0);
    chk("mid_reset_count", 32'(o_count), 32'd0);
    chk("mid_reset_valid", 32'(o_word_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(3'd1, 1'b1);
    finish_word(8'h02, 4'd1, 1'b0, 0);

    // Randomized words against a set-union model.
    for (int w = 0; w < 40; w++) begin
      n = $urandom_range(1, 10);
      q.delete();
      for (int b = 0; b < n; b++) q.push_back(3'($urandom_range(0, 7)));
      mw = 8'h00;
      foreach (q[k]) mw = mw | (8'h01 << q[k]);
      foreach (q[k]) begin
        repeat ($urandom_range(0, 1)) @(negedge clk);
        send_beat(q[k], (k == n - 1) ? 1'b1 : 1'b0);
      end
      finish_word(mw, 4'($countones(mw)), (n > $countones(mw)) ? 1'b1 : 1'b0,
                  $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_index_stream_to_word
